uncache_bridge: RTL
===================

Name: uncache_bridge

Overview:
Bus-side agent for translated, uncached accesses (MMIO/confreg region, physical 0x1FAF_xxxx).
- Accepts one CPU memory request already carrying a physical address and an uncached flag from address translation.
- Issues it as a single-beat AXI3-style read or write, then returns read data or write completion to the pipeline.
- Sits between the memory stage and the AXI crossbar, alongside the caches; strictly one transaction outstanding.

Parameters:
ADDR_W, 32, physical address width
DATA_W, 32, data bus width (STRB = DATA_W/8)
AXI_ID, 4'd2, constant ARID/AWID/WID driven on the bus

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  CPU request present
req_wr  in  1  1=store, 0=load
req_addr  in  ADDR_W  physical address
req_size  in  2  0=byte, 1=half, 2=word
req_wstrb  in  STRB  byte enables (stores)
req_wdata  in  DATA_W  store data
req_ready  out  1  request accepted this cycle
resp_valid  out  1  one-cycle pulse: load data/store done
resp_rdata  out  DATA_W  load data (raw bus word)
busy  out  1  transaction in flight (pipeline stall)
arid/araddr/arsize/arvalid  out  4/ADDR_W/3/1  read address channel
arready  in  1
rid/rdata/rresp/rlast/rvalid  in  4/DATA_W/2/1/1  read data channel
rready  out  1
awid/awaddr/awsize/awvalid  out  4/ADDR_W/3/1  write address channel
awready  in  1
wid/wdata/wstrb/wlast/wvalid  out  4/DATA_W/STRB/1/1  write data channel
wready  in  1
bid/bresp/bvalid  in  4/2/1  write response channel
bready  out  1
ARLEN/AWLEN fixed 0 and burst INCR are not ports; the integration wrapper ties them off.

Behaviour:
- All state is reset synchronously by rst. After reset:
  - state=IDLE.
  - All valid/ready outputs 0, except req_ready=1 in IDLE.
  - resp_rdata=0, busy=0.
- req_ready=1 only in IDLE. Acceptance = req_valid & req_ready.
- On acceptance, register addr, size, wstrb, wdata and wr. The request is captured; the CPU may drop it next cycle.
- Bus size = {1'b0, req_size}. Address is passed unaligned-masked: low bits kept for byte/half.
- FSM:
  - IDLE: accept. Load -> RD_A; store -> WR_AW.
  - RD_A: arvalid=1. On arready -> RD_D.
  - RD_D: rready=1. On rvalid: latch rdata into resp_rdata, pulse resp_valid next cycle -> DONE.
  - WR_AW: awvalid=1 and wvalid=1 together, tracked by flags aw_done and w_done. Each deasserts after its own handshake, in any order or the same cycle. Both done -> WR_B.
  - WR_B: bready=1. On bvalid -> DONE.
  - DONE: resp_valid=1 for exactly one cycle -> IDLE.
- Handshake rules:
  - arvalid/awvalid/wvalid, once raised, hold with stable payload until their ready.
  - Never combinationally dependent on ready.
- busy=1 in every state except IDLE. Sole guarantee: busy never drops without a resp_valid pulse.
- Latency with zero-wait slave:
  - Load: accept cycle 0, ar handshake cycle 1, r cycle 2, resp_valid cycle 3.
  - Store: aw+w cycle 1, b cycle 2, resp_valid cycle 3.
- Boundaries:
  - rresp/bresp != OKAY: ignored, transaction completes normally.
  - rid/bid not checked.
  - rlast assumed 1.
  - rvalid or bvalid arriving in a state not expecting it: ignored, not acked.
  - rst asserted mid-transaction returns to IDLE next edge, dropping the transaction. The bus is reset by the same rst.
  - req_valid while busy: not accepted; the CPU holds it.

Decomposition:
Shared package (cpu_defines):
- typedef enum uncache_state_t {IDLE, RD_A, RD_D, WR_AW, WR_B, DONE}.
- localparams AXI_SIZE_B/H/W (3'b000/001/010).
- AXI_RESP_OKAY.
- Uncached-region constants 0x1FAF_0000/16'h1FAF shared with translation.

No sub-module; a single FSM file.

Test Plan:
- Zero-wait load, addr 0x1FAF_F020, slave returns 0xDEAD_BEEF -> araddr=0x1FAF_F020, arsize=2, resp_valid at cycle 3, resp_rdata=0xDEAD_BEEF, busy high cycles 1-3.
- Store byte, addr 0x1FAF_F001, wstrb 4'b0010, wdata 0x0000_AB00 -> awsize=0, wstrb/wdata unchanged on bus, one resp_valid pulse after bvalid.
- Store with awready delayed 3 cycles and wready immediate -> wvalid drops after 1 cycle, awvalid held with stable awaddr, bready only after both handshakes.
- Load with arready and rvalid each stalled 5 cycles; req_valid held throughout -> req_ready=0 while busy, exactly one ar transaction issued.
- rst pulsed in RD_D -> next cycle IDLE, all bus valids 0, req_ready=1, no resp_valid.
- Back-to-back store then load -> second accepted the cycle after the first resp_valid, bus transactions in order, bresp=SLVERR still completes.

Source files
------------

// File: rtl/uncache_bridge_pkg.sv
// Shared types and constants for the uncached access path.
// FSM states, AXI size/response codes and the uncached-region window.
package uncache_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_D,
    WR_AW,
    WR_B,
    DONE
  } uncache_state_t;

  localparam logic [2:0] AXI_SIZE_B = 3'b000;
  localparam logic [2:0] AXI_SIZE_H = 3'b001;
  localparam logic [2:0] AXI_SIZE_W = 3'b010;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  localparam logic [31:0] UNCACHE_BASE = 32'h1FAF_0000;
  localparam logic [15:0] UNCACHE_HI   = 16'h1FAF;

  function automatic logic is_uncached(input logic [31:0] pa);
    return pa[31:16] == UNCACHE_HI;
  endfunction

endpackage

// File: rtl/uncache_bridge_if.sv
// Single-beat AXI3-style bus between the uncache bridge and the crossbar.
// master: bridge side (drives AR/AW/W, ready for R/B); slave: bus side.
interface uncache_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  localparam int STRB = DATA_W / 8;

  logic [3:0]        arid;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arsize;
  logic              arvalid;
  logic              arready;

  logic [3:0]        rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  logic [3:0]        awid;
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awsize;
  logic              awvalid;
  logic              awready;

  logic [3:0]        wid;
  logic [DATA_W-1:0] wdata;
  logic [STRB-1:0]   wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [3:0]        bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output arid, araddr, arsize, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awsize, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arsize, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awsize, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/uncache_bridge.sv
// Uncached MMIO agent: one CPU request -> one single-beat AXI read/write.
// Ports: clk/rst, CPU req_*/resp_*/busy, axi (uncache_bridge_if.master).
module uncache_bridge
  import uncache_bridge_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32,
  parameter logic [3:0] AXI_ID = 4'd2
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                req_valid,
  input  logic                req_wr,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [1:0]          req_size,
  input  logic [DATA_W/8-1:0] req_wstrb,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                req_ready,

  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                busy,

  uncache_bridge_if.master    axi
);

  localparam int STRB = DATA_W / 8;

  uncache_state_t    r_state;
  uncache_state_t    w_next;

  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic [STRB-1:0]   r_wstrb;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_aw_done;
  logic              r_w_done;

  logic              w_accept;
  logic              w_awvalid;
  logic              w_wvalid;
  logic              w_aw_ok;
  logic              w_w_ok;
  logic              w_unused;

  assign req_ready = (r_state == IDLE);
  assign w_accept  = req_valid & req_ready;

  // valids come only from registered state/flags, never from ready
  assign w_awvalid = (r_state == WR_AW) & ~r_aw_done;
  assign w_wvalid  = (r_state == WR_AW) & ~r_w_done;

  // a channel counts as done if it was done earlier or handshakes now
  assign w_aw_ok = r_aw_done | (w_awvalid & axi.awready);
  assign w_w_ok  = r_w_done  | (w_wvalid  & axi.wready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_size    <= '0;
      r_wstrb   <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr    <= req_addr;
        r_size    <= req_size;
        r_wstrb   <= req_wstrb;
        r_wdata   <= req_wdata;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (r_state == WR_AW) begin
        r_aw_done <= w_aw_ok;
        r_w_done  <= w_w_ok;
      end
      if ((r_state == RD_D) && axi.rvalid) begin
        r_rdata <= axi.rdata;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (req_valid) w_next = req_wr ? WR_AW : RD_A;
      RD_A:    if (axi.arready) w_next = RD_D;
      RD_D:    if (axi.rvalid) w_next = DONE;
      WR_AW:   if (w_aw_ok && w_w_ok) w_next = WR_B;
      WR_B:    if (axi.bvalid) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign resp_valid = (r_state == DONE);
  assign resp_rdata = r_rdata;
  assign busy       = (r_state != IDLE);

  assign axi.arid    = AXI_ID;
  assign axi.araddr  = r_addr;
  assign axi.arsize  = {1'b0, r_size};
  assign axi.arvalid = (r_state == RD_A);
  assign axi.rready  = (r_state == RD_D);

  assign axi.awid    = AXI_ID;
  assign axi.awaddr  = r_addr;
  assign axi.awsize  = {1'b0, r_size};
  assign axi.awvalid = w_awvalid;

  assign axi.wid     = AXI_ID;
  assign axi.wdata   = r_wdata;
  assign axi.wstrb   = r_wstrb;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = w_wvalid;

  assign axi.bready  = (r_state == WR_B);

  // responses, ids and rlast are deliberately not inspected
  assign w_unused = &{1'b0, axi.rid, axi.rresp, axi.rlast,
                      axi.bid, axi.bresp};

endmodule
